alu_issue_ctrl: RTL and testbench

//  Initiator side of the alu_core interface. Accepts one decoded ALU request per handshake from the

---
 rtl/alu_issue_ctrl_if.sv | 53 +++++
 rtl/alu_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the ALU issue controller, the decoder, alu_core and writeback.
// master = issue controller, slave = surrounding pipeline / alu_core.
interface alu_issue_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_opcode;
    logic [7:0] req_src1;
    logic [7:0] req_src2;
    logic       req_cy;
    logic       req_ac;
    logic       req_bit;

    logic [4:0] alu_opcode;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic       alu_cy;
    logic       alu_ac;
    logic       alu_bit;
    logic [7:0] alu_des1;
    logic [7:0] alu_des2;
    logic       alu_cy_o;
    logic       alu_ac_o;
    logic       alu_ov_o;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_des1;
    logic [7:0] rsp_des2;
    logic       rsp_cy;
    logic       rsp_ac;
    logic       rsp_ov;
    logic       rsp_err;

    modport master (
        input  req_valid, req_opcode, req_src1, req_src2,
        input  req_cy, req_ac, req_bit,
        output req_ready,
        output alu_opcode, alu_op1, alu_op2, alu_cy, alu_ac, alu_bit,
        input  alu_des1, alu_des2, alu_cy_o, alu_ac_o, alu_ov_o,
        output rsp_valid, rsp_des1, rsp_des2, rsp_cy, rsp_ac, rsp_ov, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_opcode, req_src1, req_src2,
        output req_cy, req_ac, req_bit,
        input  req_ready,
        input  alu_opcode, alu_op1, alu_op2, alu_cy, alu_ac, alu_bit,
        output alu_des1, alu_des2, alu_cy_o, alu_ac_o, alu_ov_o,
        input  rsp_valid, rsp_des1, rsp_des2, rsp_cy, rsp_ac, rsp_ov, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded request to alu_core, holds its inputs for the op latency,
// then captures the results and hands them to writeback via valid/ready.
module alu_issue_ctrl #(
    parameter int         ALU_LAT    = 1,
    parameter int         MULDIV_LAT = 4,
    parameter logic [4:0] MUL_OP     = 5'h0D,
    parameter logic [4:0] DIV_OP     = 5'h0E,
    parameter logic [4:0] OPCODE_MAX = 5'h11
) (
    input  logic             clock,
    input  logic             reset,
    alu_issue_ctrl_if.master bus
);
    localparam int MAX_LAT = (ALU_LAT > MULDIV_LAT) ? ALU_LAT : MULDIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [4:0] NOP = 5'h00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_lat;
    logic          r_err_pend;
    logic          w_accept;
    logic          w_capture;
    logic          w_release;
    logic          w_illegal;
    logic          w_muldiv;

    logic [4:0]    r_alu_opcode;
    logic [7:0]    r_alu_op1;
    logic [7:0]    r_alu_op2;
    logic          r_alu_cy;
    logic          r_alu_ac;
    logic          r_alu_bit;

    logic          r_rsp_valid;
    logic [7:0]    r_rsp_des1;
    logic [7:0]    r_rsp_des2;
    logic          r_rsp_cy;
    logic          r_rsp_ac;
    logic          r_rsp_ov;
    logic          r_rsp_err;

    assign w_illegal = bus.req_opcode > OPCODE_MAX;
    assign w_muldiv  = (bus.req_opcode == MUL_OP) ||
                       (bus.req_opcode == DIV_OP);

    // Illegal opcodes never reach the ALU; they report one cycle later.
    always_comb begin
        w_lat = CW'(ALU_LAT);
        if (w_illegal) begin
            w_lat = CW'(1);
        end else if (w_muldiv) begin
            w_lat = CW'(MULDIV_LAT);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_capture = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_err_pend   <= 1'b0;
            r_alu_opcode <= NOP;
            r_alu_op1    <= 8'h00;
            r_alu_op2    <= 8'h00;
            r_alu_cy     <= 1'b0;
            r_alu_ac     <= 1'b0;
            r_alu_bit    <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= w_lat;
            r_err_pend <= w_illegal;
            if (!w_illegal) begin
                r_alu_opcode <= bus.req_opcode;
                r_alu_op1    <= bus.req_src1;
                r_alu_op2    <= bus.req_src2;
                r_alu_cy     <= bus.req_cy;
                r_alu_ac     <= bus.req_ac;
                r_alu_bit    <= bus.req_bit;
            end
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - CW'(1);
            if (w_capture) begin
                r_alu_opcode <= NOP;
                r_alu_op1    <= 8'h00;
                r_alu_op2    <= 8'h00;
                r_alu_cy     <= 1'b0;
                r_alu_ac     <= 1'b0;
                r_alu_bit    <= 1'b0;
            end
        end
    end

    // Response data stays put after the handshake until the next capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_des1  <= 8'h00;
            r_rsp_des2  <= 8'h00;
            r_rsp_cy    <= 1'b0;
            r_rsp_ac    <= 1'b0;
            r_rsp_ov    <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err_pend;
            r_rsp_des1  <= r_err_pend ? 8'h00 : bus.alu_des1;
            r_rsp_des2  <= r_err_pend ? 8'h00 : bus.alu_des2;
            r_rsp_cy    <= r_err_pend ? 1'b0  : bus.alu_cy_o;
            r_rsp_ac    <= r_err_pend ? 1'b0  : bus.alu_ac_o;
            r_rsp_ov    <= r_err_pend ? 1'b0  : bus.alu_ov_o;
        end else if (w_release) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.alu_op1    = r_alu_op1;
    assign bus.alu_op2    = r_alu_op2;
    assign bus.alu_cy     = r_alu_cy;
    assign bus.alu_ac     = r_alu_ac;
    assign bus.alu_bit    = r_alu_bit;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_des1   = r_rsp_des1;
    assign bus.rsp_des2   = r_rsp_des2;
    assign bus.rsp_cy     = r_rsp_cy;
    assign bus.rsp_ac     = r_rsp_ac;
    assign bus.rsp_ov     = r_rsp_ov;
    assign bus.rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a latency-accurate alu_core stand-in.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_alu_issue_ctrl;
    localparam int         ALU_LAT    = 1;
    localparam int         MULDIV_LAT = 4;
    localparam logic [4:0] MUL_OP     = 5'h0D;
    localparam logic [4:0] DIV_OP     = 5'h0E;
    localparam logic [4:0] OPCODE_MAX = 5'h11;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(
        .ALU_LAT(ALU_LAT), .MULDIV_LAT(MULDIV_LAT),
        .MUL_OP(MUL_OP), .DIV_OP(DIV_OP), .OPCODE_MAX(OPCODE_MAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.master)
    );

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cy;
        logic       ac;
        logic       bt;
    } ain_t;

    typedef struct packed {
        logic [7:0] d1;
        logic [7:0] d2;
        logic       cy;
        logic       ac;
        logic       ov;
    } aout_t;

    typedef struct {
        aout_t r;
        logic  err;
        int    acc;
        int    lat;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];
    exp_t cur_e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Arbitrary but input-sensitive stand-in for alu_core's arithmetic.
    function automatic aout_t alu_fn(input ain_t x);
        aout_t o;
        o.d1 = x.a + x.b + {7'd0, x.cy};
        o.d2 = {x.op, 3'b000} ^ x.a ^ ~x.b;
        o.cy = (^(x.a & x.b)) ^ x.bt;
        o.ac = x.ac ^ x.a[3];
        o.ov = x.op[0] ^ x.b[7] ^ x.ac;
        return o;
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == MUL_OP) || (op == DIV_OP);
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        if (op > OPCODE_MAX) return 1;
        if (is_muldiv(op)) return MULDIV_LAT;
        return ALU_LAT;
    endfunction

    // alu_core model: MUL/DIV results reflect inputs held for MULDIV_LAT cycles.
    ain_t  cur_in;
    ain_t  hist [0:7];
    aout_t alu_res;

    always_comb begin
        cur_in = {bus.alu_opcode, bus.alu_op1, bus.alu_op2,
                  bus.alu_cy, bus.alu_ac, bus.alu_bit};
    end

    always @(posedge clock) begin
        hist[0] <= cur_in;
        for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
    end

    always_comb begin
        alu_res = is_muldiv(cur_in.op) ? alu_fn(hist[MULDIV_LAT-2])
                                       : alu_fn(cur_in);
        bus.alu_des1 = alu_res.d1;
        bus.alu_des2 = alu_res.d2;
        bus.alu_cy_o = alu_res.cy;
        bus.alu_ac_o = alu_res.ac;
        bus.alu_ov_o = alu_res.ov;
    end

    // rsp_ready: 0 = stalled, 1 = always ready, 2 = random
    logic [1:0] mode = 2'd1;
    logic       rnd_rdy = 1'b1;
    always @(negedge clock) rnd_rdy <= 1'($urandom_range(0, 1));
    always_comb bus.rsp_ready = (mode == 2'd2) ? rnd_rdy : mode[0];

    // A visible response is new unless the previous one was left unaccepted.
    logic new_ok;
    always @(posedge clock or posedge reset) begin
        if (reset) new_ok <= 1'b1;
        else       new_ok <= !(bus.rsp_valid && !bus.rsp_ready);
    end

    always @(negedge clock) begin
        if (!reset && bus.rsp_valid) begin
            if (new_ok) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    cur_e = q.pop_front();
                    chk("rsp_latency", cyc - cur_e.acc, cur_e.lat);
                    chk("rsp_data",
                        int'({bus.rsp_des1, bus.rsp_des2, bus.rsp_cy,
                              bus.rsp_ac, bus.rsp_ov, bus.rsp_err}),
                        int'({cur_e.r, cur_e.err}));
                end
            end else begin
                chk("rsp_hold",
                    int'({bus.rsp_des1, bus.rsp_des2, bus.rsp_cy,
                          bus.rsp_ac, bus.rsp_ov, bus.rsp_err}),
                    int'({cur_e.r, cur_e.err}));
            end
        end
    end

    // Entered and left on a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [4:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic c, input logic ac,
                        input logic bt, output int acc);
        exp_t e;
        int   n;
        bus.req_opcode = op;
        bus.req_src1   = a;
        bus.req_src2   = b;
        bus.req_cy     = c;
        bus.req_ac     = ac;
        bus.req_bit    = bt;
        bus.req_valid  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 0, 1);
            bus.req_valid = 1'b0;
            acc = cyc;
            return;
        end
        @(negedge clock);
        bus.req_valid = 1'b0;
        acc   = cyc;
        e.err = (op > OPCODE_MAX);
        e.r   = e.err ? '0 : alu_fn({op, a, b, c, ac, bt});
        e.acc = cyc;
        e.lat = lat_of(op);
        q.push_back(e);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        int acc;
        int n;
        bus.req_valid  = 1'b0;
        bus.req_opcode = 5'h00;
        bus.req_src1   = 8'h00;
        bus.req_src2   = 8'h00;
        bus.req_cy     = 1'b0;
        bus.req_ac     = 1'b0;
        bus.req_bit    = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_req_ready", int'(bus.req_ready), 1);
        chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
        chk("reset_alu_opcode", int'(bus.alu_opcode), 0);
        chk("reset_rsp_err", int'(bus.rsp_err), 0);
        reset = 1'b0;
        @(negedge clock);

        // ADD
        send(5'h01, 8'h40, 8'h20, 1'b1, 1'b0, 1'b0, acc);
        chk("add_alu_opcode", int'(bus.alu_opcode), 1);
        chk("add_alu_op1", int'(bus.alu_op1), 'h40);
        chk("add_alu_op2", int'(bus.alu_op2), 'h20);
        chk("add_alu_cy", int'(bus.alu_cy), 1);
        wait_ready(n);

        // MUL: inputs held for the whole latency
        send(MUL_OP, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, acc);
        for (int k = 0; k < MULDIV_LAT; k++) begin
            chk("mul_alu_opcode_hold", int'(bus.alu_opcode), int'(MUL_OP));
            chk("mul_alu_op1_hold", int'(bus.alu_op1), 'h10);
            @(negedge clock);
        end
        wait_ready(n);

        // Backpressure
        mode = 2'd0;
        send(5'h03, 8'hA5, 8'h5A, 1'b1, 1'b1, 1'b1, acc);
        repeat (6) begin
            @(negedge clock);
            chk("bp_req_ready", int'(bus.req_ready), 0);
            chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
        end
        mode = 2'd1;
        @(negedge clock);
        chk("bp_release_ready", int'(bus.req_ready), 1);
        chk("bp_release_valid", int'(bus.rsp_valid), 0);

        // Illegal opcode
        send(5'h1F, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, acc);
        chk("illegal_alu_opcode", int'(bus.alu_opcode), 0);
        wait_ready(n);

        // Opcodes 1..17 in sequence
        for (int op = 1; op <= 17; op++) begin
            send(5'(op), 8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), acc);
            wait_ready(n);
            chk("seq_ready_gap", n, lat_of(5'(op)) + 1);
        end

        // Reset in the middle of a DIV
        send(DIV_OP, 8'h99, 8'h07, 1'b0, 1'b0, 1'b0, acc);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_req_ready", int'(bus.req_ready), 1);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_alu_opcode", int'(bus.alu_opcode), 0);
        q.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (8) begin
            @(negedge clock);
            chk("rst_no_stale", int'(bus.rsp_valid), 0);
        end

        // Random traffic with random backpressure
        mode = 2'd2;
        repeat (150) begin
            send(5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), acc);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        mode = 2'd1;
        n = 0;
        while ((q.size() != 0 || !bus.req_ready) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_idle", int'(bus.req_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
